mix_columns_engine: RTL and testbench
=====================================

Name: mix_columns_engine

Overview:
- Parametrised AES MixColumns / InvMixColumns engine for the round datapath.
- Takes a full 128-bit state through a valid/ready handshake. Computes COLS_PER_CYCLE columns per clock using combinational xtime-based GF(2^8) multipliers; no multi-cycle multiplier handshake.
- Returns the transformed state through a valid/ready output handshake.
- Adds a runtime inverse mode, selectable throughput, back-to-back operation and output backpressure.

Parameters:
- COLS_PER_CYCLE, 1, columns processed per clock; legal values 1, 2, 4; any other value is an elaboration error.
- STEPS, 4/COLS_PER_CYCLE, derived localparam, not overridable: compute cycles per state.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  state_in and inv are valid
- in_ready  out  1  engine can accept a state
- inv  in  1  0 = MixColumns (matrix 02 03 01 01), 1 = InvMixColumns (0e 0b 0d 09); sampled at the accept edge
- state_in  in  128  {w0,w1,w2,w3}; w0 = [127:96]; within each word, byte [31:24] is row 0, [7:0] is row 3
- out_valid  out  1  state_out holds a complete result
- out_ready  in  1  consumer accepts the result
- state_out  out  128  transformed state, same packing as state_in
- busy  out  1  high while in COMPUTE

Behaviour:
- Reset (async assert, sync release): state=IDLE, col_idx=0, out_valid=0, busy=0, state_out=0, internal state/mode registers=0. Reset mid-COMPUTE or mid-DONE aborts the operation; the partial result is discarded.
- Accept: in_valid && in_ready at a rising edge. At that edge, latch state_in and inv; col_idx<=0.
- FSM states:
  - IDLE: in_ready=1. On accept -> COMPUTE.
  - COMPUTE: in_ready=0, busy=1.
    - Each edge: columns col_idx*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1 are computed and written into the result register; col_idx increments.
    - At the edge where the last group is written -> DONE, out_valid<=1.
  - DONE: out_valid=1, and state_out is stable while out_ready=0.
    - On out_ready=1: out_valid clears at that edge.
    - in_ready = out_ready in DONE. If in_valid is also high at the same edge, the new input is accepted -> COMPUTE (back-to-back). Otherwise -> IDLE.
- Latency: accept at edge t gives out_valid=1 after edge t+STEPS (1, 2 or 4 cycles). Throughput with out_ready tied high is one state every STEPS+1 cycles.
- Column math, per column (a0..a3), forward mode: r_i = 02*a_i ^ 03*a_{i+1} ^ a_{i+2} ^ a_{i+3}, indices mod 4.
- Inverse mode: r_i = 0e*a_i ^ 0b*a_{i+1} ^ 0d*a_{i+2} ^ 09*a_{i+3}.
- Multiplication is in GF(2^8) mod x^8+x^4+x^3+x+1 (0x11b). xtime(b) = (b<<1) ^ (b[7] ? 0x1b : 0), 8-bit results, and addition is XOR.
- The mode and the input state are held in internal registers during COMPUTE; changes on inv/state_in after accept are ignored.
- state_out updates only when the final group is written. Earlier partial columns are held internally, so state_out never shows a mixed old/new state while out_valid=1.
- in_valid while not ready: no effect; upstream must hold its data.
- out_ready while out_valid=0: ignored.

Test Plan:
1. Forward, COLS_PER_CYCLE=4: state_in columns db135345, f20a225c, 01010101, c6c6c6c6 -> state_out 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6. out_valid must assert exactly 1 cycle after accept.
2. Same vector with COLS_PER_CYCLE=1 and 2 -> identical state_out. out_valid must assert 4 and 2 cycles after accept respectively. busy must be high for exactly STEPS cycles.
3. Inverse mode: inv=1, columns 8e4da1bc, 9fdc589d, d4d4d4d5 -> output columns db135345, f20a225c, and the column that forward-mixes to d4d4d4d5. Also run a round-trip check: forward output fed back with inv=1 returns the original state, using column d4d4d4d5 -> d5d5d7d6 and its inverse.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> state_out stable, in_ready=0, and a new in_valid is not accepted. Then raise out_ready and in_valid together -> the result is retired and the new state accepted on the same edge, with no idle cycle.
5. Mode latch: change inv and state_in on the cycle after accept with COLS_PER_CYCLE=1 -> the result matches the originally latched inputs.
6. Reset mid-COMPUTE at col_idx=2 -> out_valid=0, state_out=0, in_ready=1 immediately (async). The next accepted state completes correctly.

Source files
------------

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine.
// Accepts one 128-bit state, mixes COLS_PER_CYCLE columns per clock and
// presents the complete result on a valid/ready output port.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data steady until that edge.
// Ready may depend on the other side's ready. in_ready follows out_ready
// in DONE, so a result can be retired and a new state taken on one edge.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int STEPS = 4 / COLS_PER_CYCLE;

  // Only 1, 2 and 4 divide the four columns evenly.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   col_idx;
  logic [127:0] in_reg;
  logic         mode_reg;
  logic [127:0] res_reg;
  logic [127:0] next_res;
  logic         last_step;
  logic         accept;

  // Multiply by 02 in GF(2^8), reduced by 0x11b.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column, row 0 in the top byte. The inverse coefficients are built
  // from the 02/04/08 multiples: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_mode);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] r;
    logic [1:0]  j0, j1, j2, j3;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      j0 = 2'(i);
      j1 = j0 + 2'd1;
      j2 = j0 + 2'd2;
      j3 = j0 + 2'd3;
      if (inv_mode)
        r[31-8*i -: 8] = (x8[j0] ^ x4[j0] ^ x2[j0]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
                         (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
      else
        r[31-8*i -: 8] = x2[j0] ^ (x2[j1] ^ a[j1]) ^ a[j2] ^ a[j3];
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_step = (col_idx == 2'(STEPS - 1));

  // Merge this cycle's column group into the partial result.
  always_comb begin
    int c;
    c        = 0;
    next_res = res_reg;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      c = int'(col_idx) * COLS_PER_CYCLE + g;
      next_res[127-32*c -: 32] = mix_col(in_reg[127-32*c -: 32], mode_reg);
    end
  end

  // Control FSM and datapath registers; state_out only loads the full result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_idx   <= 2'd0;
      in_reg    <= '0;
      mode_reg  <= 1'b0;
      res_reg   <= '0;
      state_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_reg   <= state_in;
            mode_reg <= inv;
            col_idx  <= 2'd0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_reg <= next_res;
          col_idx <= col_idx + 2'd1;
          if (last_step) begin
            state_out <= next_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              in_reg   <= state_in;
              mode_reg <= inv;
              col_idx  <= 2'd0;
              busy     <= 1'b1;
              state    <= COMPUTE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Bench for mix_columns_engine: three instances (1, 2 and 4 columns per
// cycle) driven with a table of hand-computed vectors plus backpressure,
// input-latch and mid-operation reset sequences.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   iv, ir, invs, ov, ordy, bz;
  logic [127:0] si [3];
  logic [127:0] so [3];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [7];

  // clock / reset
  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .inv(invs[0]),
    .state_in(si[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .state_out(so[0]), .busy(bz[0]));
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .inv(invs[1]),
    .state_in(si[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .state_out(so[1]), .busy(bz[1]));
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .inv(invs[2]),
    .state_in(si[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .state_out(so[2]), .busy(bz[2]));

  function automatic int steps_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Wait (bounded) for out_valid on instance k; returns negedges waited, -1 on timeout.
  task automatic wait_valid(input int k, output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov[k]) begin
        lat = c;
        break;
      end
      if (bz[k]) busy_cnt++;
    end
  endtask

  // Driver: one full transaction; inputs are scrambled right after accept.
  task automatic apply(input int k, input vec_t v, input string name);
    int lat, bcnt;
    @(negedge clk);
    chk({name, "_in_ready"}, 128'(ir[k]), 128'(1));
    iv[k] = 1'b1; invs[k] = v.inv; si[k] = v.din;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0; invs[k] = ~v.inv; si[k] = {$urandom, $urandom, $urandom, $urandom};
    chk({name, "_busy_first"}, 128'(bz[k]), 128'(1));
    lat = -1; bcnt = 1;
    if (!ov[k]) begin
      wait_valid(k, lat, bcnt);
      if (lat >= 0) begin
        lat = lat + 1;
        bcnt = bcnt + 1;
      end
    end else begin
      lat = 0;
    end
    chk({name, "_latency"}, 128'(lat), 128'(steps_of(k)));
    chk({name, "_busy_cycles"}, 128'(bcnt), 128'(steps_of(k)));
    chk({name, "_state_out"}, so[k], v.dout);
  endtask

  // Output stall with a competing input, then retire + accept on one edge.
  task automatic backpressure(input int k);
    int lat, bcnt;
    ordy[k] = 1'b0;
    @(negedge clk);
    iv[k] = 1'b1; invs[k] = vecs[0].inv; si[k] = vecs[0].din;
    @(posedge clk);
    @(negedge clk);
    invs[k] = vecs[4].inv; si[k] = vecs[4].din;
    if (!ov[k]) wait_valid(k, lat, bcnt);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 128'(ov[k]), 128'(1));
      chk("bp_hold_data", so[k], vecs[0].dout);
      chk("bp_in_ready_low", 128'(ir[k]), 128'(0));
      @(negedge clk);
    end
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0; si[k] = '0;
    chk("bp_retired", 128'(ov[k]), 128'(0));
    chk("bp_b2b_busy", 128'(bz[k]), 128'(1));
    if (!ov[k]) wait_valid(k, lat, bcnt);
    chk("bp_second_result", so[k], vecs[4].dout);
  endtask

  initial begin
    vecs[0] = '{1'b0, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6},
                      {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}};
    vecs[1] = '{1'b1, {32'h8e4da1bc, 32'h9fdc589d, 32'hd4d4d4d5, 32'hc6c6c6c6},
                      {32'hdb135345, 32'hf20a225c, 32'hddd9dfda, 32'hc6c6c6c6}};
    vecs[2] = '{1'b0, {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5},
                      {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6}};
    vecs[3] = '{1'b1, {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6},
                      {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5}};
    vecs[4] = '{1'b0, {32'h01000000, 32'h80000000, 32'h00000000, 32'hffffffff},
                      {32'h02010103, 32'h1b80809b, 32'h00000000, 32'hffffffff}};
    vecs[5] = '{1'b1, {32'h01000000, 32'h00000001, 32'h00000000, 32'hffffffff},
                      {32'h0e090d0b, 32'h090d0b0e, 32'h00000000, 32'hffffffff}};
    vecs[6] = '{1'b0, {32'hddd9dfda, 32'h00000000, 32'h00000000, 32'h00000000},
                      {32'hd4d4d4d5, 32'h00000000, 32'h00000000, 32'h00000000}};

    rst = 1'b1; iv = '0; invs = '0; ordy = '1;
    for (int k = 0; k < 3; k++) si[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_out_valid", 128'(ov[k]), 128'(0));
      chk("reset_state_out", so[k], 128'(0));
      chk("reset_busy", 128'(bz[k]), 128'(0));
      chk("reset_in_ready", 128'(ir[k]), 128'(1));
    end
    rst = 1'b0;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 7; i++)
        apply(k, vecs[i], $sformatf("vec%0d_cols%0d", i, (k == 0) ? 1 : (k == 1) ? 2 : 4));

    backpressure(1);
    backpressure(2);
    backpressure(0);

    // Reset while instance 0 is partway through its columns.
    @(negedge clk);
    iv[0] = 1'b1; invs[0] = vecs[2].inv; si[0] = vecs[2].din;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(ov[0]), 128'(0));
    chk("rst_mid_state_out", so[0], 128'(0));
    chk("rst_mid_in_ready", 128'(ir[0]), 128'(1));
    chk("rst_mid_busy", 128'(bz[0]), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    apply(0, vecs[3], "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
